// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage.
//   - memory-to-write-back bus width and its packed field layout
//   - CP0 register numbers and exception codes
//   - default exception vector and Status reset value
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD = 150;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EX_ENTRY_DEF     = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RESET_DEF = 32'h0040_0000;

  // Field order matches the bus bit layout, MSB first (150 bits total).
  typedef struct packed {
    logic        fetch_ae;      // [149]
    logic [31:0] rt_val;        // [148:117]
    logic        eret;          // [116]
    logic        bd;            // [115]
    logic        mtc0_we;       // [114]
    logic [4:0]  cp0_addr;      // [113:109]
    logic        res_from_cp0;  // [108]
    logic [31:0] alu_res;       // [107:76]
    logic        ex;            // [75]
    logic [4:0]  excode;        // [74:70]
    logic        gr_we;         // [69]
    logic [4:0]  dest;          // [68:64]
    logic [31:0] result;        // [63:32]
    logic [31:0] pc;            // [31:0]
  } ms_to_ws_t;

  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to write-back-stage handshake.
//   ms_to_ws_valid : upstream has an instruction
//   ms_to_ws_bus   : packed instruction fields (see wb_stage_pkg::ms_to_ws_t)
//   ws_allowin     : write-back can accept
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       ws_allowin;

  modport master (output ms_to_ws_valid, output ms_to_ws_bus, input ws_allowin);
  modport slave  (input ms_to_ws_valid, input ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage_cp0_regfile.sv
// Architectural CP0 state: Status, Cause, EPC, BadVAddr, Count, Compare.
// Inputs are commit strobes already qualified by the write-back stage
// (ex_commit, eret_commit, mtc0_we) plus the committing instruction's fields.
// Outputs: rdata (read mux on cp0_addr), epc (eret target), has_int.
module wb_stage_cp0_regfile
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] STATUS_RESET = STATUS_RESET_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_commit,
  input  logic        eret_commit,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  excode,
  input  logic        bd,
  input  logic        fetch_ae,
  input  logic [31:0] pc,
  input  logic [31:0] alu_res,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        has_int
);

  // Status keeps its full word so the non-writable BEV bit stays at its reset value.
  logic [31:0] status_q, status_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;

  logic [7:0]  cause_ip;
  logic [31:0] cause_rd;

  assign cause_ip = {ti_q, 5'b0, ip_sw_q};
  assign cause_rd = {bd_q, ti_q, 14'b0, cause_ip, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    status_d   = status_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    tick_d     = ~tick_q;

    // A software write to Count takes precedence over the tick increment.
    if (mtc0_we && cp0_addr == CP0_COUNT) begin
      count_d = wdata;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end

    // Writing Compare acknowledges the timer, even on a coincident match.
    if (mtc0_we && cp0_addr == CP0_COMPARE) begin
      ti_d = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end

    if (ex_commit) begin
      status_d[1] = 1'b1;
      exc_code_d  = excode;
      // Nested exceptions keep the original return context.
      if (!status_q[1]) begin
        epc_d = bd ? (pc - 32'd4) : pc;
        bd_d  = bd;
      end
      if (is_addr_err(excode)) begin
        badvaddr_d = fetch_ae ? pc : alu_res;
      end
    end else if (eret_commit) begin
      status_d[1] = 1'b0;
    end

    if (mtc0_we) begin
      case (cp0_addr)
        CP0_STATUS: begin
          status_d[15:8] = wdata[15:8];
          status_d[1:0]  = wdata[1:0];
        end
        CP0_CAUSE:   ip_sw_d   = wdata[9:8];
        CP0_EPC:     epc_d     = wdata;
        CP0_COMPARE: compare_d = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= STATUS_RESET;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= 2'b0;
      exc_code_q <= 5'b0;
      epc_q      <= 32'b0;
      badvaddr_q <= 32'b0;
      count_q    <= 32'b0;
      compare_q  <= 32'b0;
      tick_q     <= 1'b0;
    end else begin
      status_q   <= status_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    rdata = 32'b0;
    case (cp0_addr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_COUNT:    rdata = count_q;
      CP0_COMPARE:  rdata = compare_q;
      CP0_STATUS:   rdata = status_q;
      CP0_CAUSE:    rdata = cause_rd;
      CP0_EPC:      rdata = epc_q;
      default:      rdata = 32'b0;
    endcase
  end

  assign epc     = epc_q;
  assign has_int = (|(cause_ip & status_q[15:8])) & status_q[0] & ~status_q[1];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle into the GPR file,
// commits exceptions/eret (flush + refetch target) and drives debug trace.
//   clk, resetn        : clock, async active-low reset
//   ms_if (slave)      : valid/bus from memory stage, ws_allowin back
//   rf_we/waddr/wdata  : GPR write port
//   ex_from_ws         : flush of all younger stages, ex_target refetch PC
//   has_int            : pending enabled interrupt to decode
//   ws_forward_bus     : forwarding copy of rf_wdata
//   debug_wb_*         : retirement trace
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY     = EX_ENTRY_DEF,
  parameter logic [31:0] STATUS_RESET = STATUS_RESET_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  wb_stage_if.slave   ms_if,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ex_from_ws,
  output logic [31:0] ex_target,
  output logic        has_int,
  output logic [31:0] ws_forward_bus,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  ms_to_ws_t   bus_q, bus_d;
  logic        ws_valid_q, ws_valid_d;
  logic        ex_commit, eret_commit, mtc0_commit;
  logic [31:0] cp0_rdata, cp0_epc;

  assign ms_if.ws_allowin = 1'b1;

  always_comb begin
    bus_d      = ms_if.ms_to_ws_valid ? ms_to_ws_t'(ms_if.ms_to_ws_bus) : bus_q;
    // The instruction behind a committing exception/eret is squashed.
    ws_valid_d = ms_if.ms_to_ws_valid & ~ex_from_ws;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_q      <= '0;
      ws_valid_q <= 1'b0;
    end else begin
      bus_q      <= bus_d;
      ws_valid_q <= ws_valid_d;
    end
  end

  assign ex_commit   = ws_valid_q & bus_q.ex;
  assign eret_commit = ws_valid_q & bus_q.eret & ~bus_q.ex;
  assign mtc0_commit = ws_valid_q & bus_q.mtc0_we & ~bus_q.ex;

  wb_stage_cp0_regfile #(
    .STATUS_RESET (STATUS_RESET)
  ) cp0_regfile (
    .clk         (clk),
    .resetn      (resetn),
    .ex_commit   (ex_commit),
    .eret_commit (eret_commit),
    .mtc0_we     (mtc0_commit),
    .cp0_addr    (bus_q.cp0_addr),
    .wdata       (bus_q.rt_val),
    .excode      (bus_q.excode),
    .bd          (bus_q.bd),
    .fetch_ae    (bus_q.fetch_ae),
    .pc          (bus_q.pc),
    .alu_res     (bus_q.alu_res),
    .rdata       (cp0_rdata),
    .epc         (cp0_epc),
    .has_int     (has_int)
  );

  always_comb begin
    rf_we      = ws_valid_q & bus_q.gr_we & ~bus_q.ex;
    rf_waddr   = ws_valid_q ? bus_q.dest : 5'b0;
    rf_wdata   = 32'b0;
    if (ws_valid_q) begin
      rf_wdata = bus_q.res_from_cp0 ? cp0_rdata : bus_q.result;
    end
    ex_from_ws = ws_valid_q & (bus_q.ex | bus_q.eret);
    ex_target  = 32'b0;
    if (ws_valid_q) begin
      ex_target = bus_q.eret ? cp0_epc : EX_ENTRY;
    end
  end

  assign ws_forward_bus    = rf_wdata;
  assign debug_wb_pc       = ws_valid_q ? bus_q.pc : 32'b0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (write-back) pipeline stage. Directly consumes the memory stage's ms_to_ws_valid/ms_to_ws_bus.
- Retires one instruction per cycle into the GPR file and owns architectural CP0 state: Status, Cause, EPC, BadVAddr, Count, Compare.
- Commits exceptions and eret, then drives the pipeline-wide flush (ex_from_ws) and the refetch target.
- Drives the interrupt request seen by decode and the debug trace.

Parameters:
- MS_TO_WS_BUS_WD, 150, input bus width (shared-package constant).
- EX_ENTRY, 32'hBFC0_0380, exception vector.
- STATUS_RESET, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ws_allowin  out  1  stage can accept; constant 1.
- ms_to_ws_valid  in  1  upstream valid.
- ms_to_ws_bus  in  150  fields: [149] fetch addr-error, [148:117] rt value, [116] eret, [115] branch-delay, [114] mtc0 we, [113:109] cp0 addr, [108] result-from-cp0, [107:76] alu result (data BadVAddr), [75] ex, [74:70] excode, [69] gr_we, [68:64] dest, [63:32] final result, [31:0] pc.
- rf_we  out  1  GPR write enable.
- rf_waddr  out  5  GPR write index.
- rf_wdata  out  32  GPR write data.
- ex_from_ws  out  1  flush of all younger stages.
- ex_target  out  32  refetch PC.
- has_int  out  1  pending enabled interrupt (to decode).
- ws_forward_bus  out  32  equals rf_wdata.
- debug_wb_pc  out  32  retiring pc.
- debug_wb_rf_wen  out  4  byte enables.
- debug_wb_rf_wnum  out  5  debug write index.
- debug_wb_rf_wdata  out  32  debug write data.

Behaviour:
- Reset (async, resetn=0):
  - ws_valid=0, bus register=0, all outputs 0.
  - Status=STATUS_RESET; Cause, EPC, BadVAddr, Count, Compare=0; count-tick toggle=0.
- Handshake:
  - ws_ready_go=1, ws_allowin=1.
  - Bus register loads on ms_to_ws_valid.
  - ws_valid<=ms_to_ws_valid each cycle, but is forced to 0 the cycle after ex_from_ws.
  - Latency: one cycle from bus capture to commit.
- Commit combinationals (all gated by ws_valid):
  - rf_we = gr_we & ~ex.
  - rf_wdata = res_from_cp0 ? cp0 read data(cp0 addr) : final result.
  - debug_wb_rf_wen = {4{rf_we}}.
- Flush:
  - ex_from_ws = ws_valid & (ex | eret).
  - ex_target = eret ? EPC : EX_ENTRY.
  - Valid for exactly the committing cycle.
- On exception commit (ws_valid & ex):
  - Status.EXL<=1.
  - Cause.ExcCode[6:2]<=excode.
  - If EXL was 0: EPC<=bd ? pc-4 : pc and Cause.BD<=bd. If EXL was already 1, EPC/BD are held.
  - excode 0x04/0x05 (AdEL/AdES): BadVAddr<=fetch addr-error ? pc : alu result.
  - mtc0 on an excepting instruction is suppressed (exception wins).
- On eret commit: Status.EXL<=0.
- mtc0 (ws_valid & mtc0_we & ~ex), data = rt value, writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC, Count, Compare: full word.
  - BadVAddr is read-only.
  - Compare write clears Cause.TI.
- Count and timer interrupt:
  - Count increments when the tick toggle is 1 (every second cycle); 32-bit wrap FFFF_FFFF->0.
  - mtc0 Count in a tick cycle: the written value wins and no increment occurs.
  - Cause.TI sets when Count==Compare and ws is not writing Compare.
  - Compare write in the same cycle as a match: TI is cleared (write wins).
  - Cause.IP[7] mirrors TI; IP[6:2]=0.
- has_int = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL.
- Reset mid-operation: all state clears immediately; no commit occurs in the reset cycle.

Decomposition:
- Shared package (existing header):
  - MS_TO_WS_BUS_WD.
  - CP0 register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14.
  - Excode constants: INT 00, ADEL 04, ADES 05, SYS 08, BP 09, RI 0A, OV 0C.
  - EX_ENTRY.
- One sub-module, cp0_regfile.
  - Owns all CP0 registers, the count tick, TI and has_int.
  - Inputs: commit strobes (ex, eret, mtc0), fields, pc.
  - Output: read mux.
- wb_stage keeps the pipeline register, GPR write and debug logic.

Test Plan:
- addu commit: bus pc=BFC00010, dest=5, gr_we=1, result=1234 -> next cycle rf_we=1, waddr=5, wdata=00001234, debug_wb_rf_wen=F, ex_from_ws=0.
- Syscall in delay slot: ex=1, excode=08, bd=1, pc=BFC00104 -> ex_from_ws=1, target=BFC00380, EPC=BFC00100, Cause.BD=1, ExcCode=08, EXL=1, rf_we=0.
- Load address error: excode=04, alu result=00000003 -> BadVAddr=00000003. Fetch-error variant with pc=BFC00021 -> BadVAddr=BFC00021.
- eret after mtc0 EPC=BFC00200 -> target=BFC00200, EXL=0. A second exception while EXL=1 leaves EPC unchanged.
- Timer: mtc0 Compare=00000010, Count=0000000E -> TI=1 after 4 cycles; with IE=1, IM7=1 -> has_int=1. Rewriting Compare -> TI=0.
- Reset asserted while a committing mtc0 Status is in flight -> Status=00400000, ws_valid=0, no rf_we; Count=FFFFFFFF wraps to 0 on its tick.
